cpu_rf_wb_arb: RTL and testbench

Write-port arbiter and scheduler for the CPU register file (16 x 32-bit, one write port, two read ports). It accepts register writes from several producers (ALU writeback, load writeback, accelerator result), buffers each producer in a small FIFO, and grants the single `cpu_rf` write port round-robin. It also exports a per-register pending mask so issue logic can stall on RAW and cross-producer WAW hazards. It sits between the execute/memory stages and `cpu_rf`.

---
 rtl/cpu_rf_wb_arb.sv | 209 ++++++++++++++++++++
 tb/tb_cpu_rf_wb_arb.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_rf_wb_arb.sv
// Purpose: round-robin arbiter granting the single cpu_rf write port to NREQ buffered producers (ALU, MEM, ACC).
// Latency: 2 edges from enqueue handshake to RF capture (FIFO head, then registered output stage).
// Backpressure: per-requester registered req_ready drops while that FIFO holds DEPTH entries; the RF never stalls.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   flush                 synchronous discard of every queued and staged write
//   req_valid/req_ready   per-requester write handshake
//   req_sel/req_data      per-requester destination register and data, packed by requester index
//   rf_wrt_en/sel/data    registered write beat into cpu_rf
//   gnt_id                requester that sourced the current write beat
//   pend_mask             one bit per register, set while a write to it is queued or staged

// Small FIFO with a registered "can accept" flag derived from the next occupancy.
module cpu_rf_wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic         rdy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    assign head_dat = mem[rd_ptr];
    assign empty    = (count == '0);

    always_comb begin
        count_nxt = count;
        if (clr) begin
            count_nxt = '0;
        end else begin
            count_nxt = count + CW'(push) - CW'(pop);
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy    <= 1'b0;
        end else begin
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            rdy   <= (count_nxt < CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= push_dat;
    end
endmodule

module cpu_rf_wb_arb #(
    parameter int NREQ   = 3,
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int REG_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*REG_W-1:0]    req_sel,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic                     rf_wrt_en,
    output logic [REG_W-1:0]         rf_wrt_sel,
    output logic [DATA_W-1:0]        rf_wrt_data,
    output logic [$clog2(NREQ)-1:0]  gnt_id,
    output logic [2**REG_W-1:0]      pend_mask
);
    localparam int IDW  = $clog2(NREQ);
    localparam int NREG = 2**REG_W;
    // Worst case in flight per register: every FIFO slot plus the staged beat.
    localparam int CNTW = $clog2(NREQ*DEPTH + 2);

    typedef struct packed {
        logic [REG_W-1:0]  sel;
        logic [DATA_W-1:0] dat;
    } wr_ent_t;

    logic [NREQ-1:0] push;
    logic [NREQ-1:0] pop;
    logic [NREQ-1:0] empty;
    wr_ent_t         head     [NREQ];
    wr_ent_t         push_ent [NREQ];

    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_vld;
    int              cand;

    logic [CNTW-1:0] pend_cnt [NREG];
    logic [CNTW-1:0] pend_nxt [NREG];

    // Flush discards same-cycle handshakes and suppresses the pop.
    for (genvar g = 0; g < NREQ; g++) begin : g_fifo
        assign push[g]         = req_valid[g] & req_ready[g] & ~flush;
        assign pop[g]          = gnt_vld & (gnt_idx == IDW'(g)) & ~flush;
        assign push_ent[g].sel = req_sel[g*REG_W +: REG_W];
        assign push_ent[g].dat = req_data[g*DATA_W +: DATA_W];

        cpu_rf_wb_fifo #(
            .W     ($bits(wr_ent_t)),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .clr      (flush),
            .push     (push[g]),
            .push_dat (push_ent[g]),
            .pop      (pop[g]),
            .head_dat (head[g]),
            .empty    (empty[g]),
            .rdy      (req_ready[g])
        );
    end

    // First non-empty FIFO at or after rr_ptr, wrapping. Only registered
    // FIFO state is examined, so a same-cycle enqueue cannot win.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(rr_ptr) + k) % NREQ;
            if (!gnt_vld && !empty[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDW'(cand);
            end
        end
    end

    // Output stage. sel/data/id hold when idle so the RF port stays quiet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wrt_en   <= 1'b0;
            rf_wrt_sel  <= '0;
            rf_wrt_data <= '0;
            gnt_id      <= '0;
            rr_ptr      <= '0;
        end else if (flush) begin
            rf_wrt_en <= 1'b0;
        end else if (gnt_vld) begin
            rf_wrt_en   <= 1'b1;
            rf_wrt_sel  <= head[gnt_idx].sel;
            rf_wrt_data <= head[gnt_idx].dat;
            gnt_id      <= gnt_idx;
            rr_ptr      <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        end else begin
            rf_wrt_en <= 1'b0;
        end
    end

    // Per-register in-flight count: +1 per enqueue, -1 when the staged beat
    // retires. The decrement never underflows since the staged beat is counted.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pend_nxt[r] = pend_cnt[r];
            for (int i = 0; i < NREQ; i++) begin
                if (push[i] && (req_sel[i*REG_W +: REG_W] == REG_W'(r))) begin
                    pend_nxt[r] = pend_nxt[r] + 1'b1;
                end
            end
            if (rf_wrt_en && (rf_wrt_sel == REG_W'(r))) begin
                pend_nxt[r] = pend_nxt[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) pend_cnt[r] <= '0;
        end else if (flush) begin
            for (int r = 0; r < NREG; r++) pend_cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) pend_cnt[r] <= pend_nxt[r];
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int r = 0; r < NREG; r++) begin
            pend_mask[r] = (pend_cnt[r] != '0);
        end
    end
endmodule

// File: tb/tb_cpu_rf_wb_arb.sv
// Purpose: randomized and directed checks of cpu_rf_wb_arb against a queue-based reference model.
// Latency: model expects 2 edges enqueue-to-RF and one write retired per cycle.
// Backpressure: model ready = queue occupancy below DEPTH after each edge.
module tb_cpu_rf_wb_arb;
    localparam int NREQ   = 3;
    localparam int DEPTH  = 2;
    localparam int DATA_W = 32;
    localparam int REG_W  = 4;
    localparam int NREG   = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [2:0]    req_valid;
    logic [2:0]    req_ready;
    logic [11:0]   req_sel;
    logic [95:0]   req_data;
    logic          rf_wrt_en;
    logic [3:0]    rf_wrt_sel;
    logic [31:0]   rf_wrt_data;
    logic [1:0]    gnt_id;
    logic [15:0]   pend_mask;

    always #5 clk = ~clk;

    cpu_rf_wb_arb #(
        .NREQ   (NREQ),
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_sel     (req_sel),
        .req_data    (req_data),
        .rf_wrt_en   (rf_wrt_en),
        .rf_wrt_sel  (rf_wrt_sel),
        .rf_wrt_data (rf_wrt_data),
        .gnt_id      (gnt_id),
        .pend_mask   (pend_mask)
    );

    // Image of cpu_rf, written from the DUT write port as the RF would.
    logic [31:0] rf_img [NREG];
    always @(posedge clk) begin
        if (rf_wrt_en) rf_img[rf_wrt_sel] <= rf_wrt_data;
    end

    // Reference model: one queue per producer plus the staged beat.
    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] dat;
    } wr_t;

    wr_t         mq [NREQ][$];
    logic [2:0]  m_rdy;
    logic        m_en;
    logic [3:0]  m_sel;
    logic [31:0] m_dat;
    logic [1:0]  m_id;
    int          m_rr;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) mq[i].delete();
        m_rdy = '0;
        m_en  = 1'b0;
        m_sel = '0;
        m_dat = '0;
        m_id  = '0;
        m_rr  = 0;
    endtask

    // A register is pending while any write to it sits in a queue or the output stage.
    function automatic logic [15:0] exp_pend();
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < NREQ; i++)
            for (int j = 0; j < mq[i].size(); j++) p[mq[i][j].sel] = 1'b1;
        if (m_en) p[m_sel] = 1'b1;
        return p;
    endfunction

    // One clock edge: advance the model with the inputs held across the edge,
    // then compare every output 1 time unit after the edge.
    task automatic step();
        logic [2:0] hs;
        bit         granted;
        int         idx;
        wr_t        e;
        for (int i = 0; i < NREQ; i++) hs[i] = req_valid[i] && m_rdy[i] && !flush;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (flush) begin
            for (int i = 0; i < NREQ; i++) mq[i].delete();
            m_en  = 1'b0;
            m_rdy = '1;
        end else begin
            granted = 0;
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_rr + k) % NREQ;
                if (!granted && mq[idx].size() > 0) begin
                    e       = mq[idx].pop_front();
                    m_sel   = e.sel;
                    m_dat   = e.dat;
                    m_id    = 2'(idx);
                    m_rr    = (idx + 1) % NREQ;
                    granted = 1;
                end
            end
            m_en = granted;
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i]) begin
                    e.sel = req_sel[i*4 +: 4];
                    e.dat = req_data[i*32 +: 32];
                    mq[i].push_back(e);
                end
            end
            for (int i = 0; i < NREQ; i++) m_rdy[i] = (mq[i].size() < DEPTH);
        end
        #1;
        chk("req_ready",   req_ready,   m_rdy);
        chk("rf_wrt_en",   rf_wrt_en,   m_en);
        chk("rf_wrt_sel",  rf_wrt_sel,  m_sel);
        chk("rf_wrt_data", rf_wrt_data, m_dat);
        chk("gnt_id",      gnt_id,      m_id);
        chk("pend_mask",   pend_mask,   exp_pend());
    endtask

    task automatic idle_in();
        req_valid = '0;
        req_sel   = '0;
        req_data  = '0;
        flush     = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [3:0] sel, input logic [31:0] dat);
        req_valid[i]          = 1'b1;
        req_sel[i*4 +: 4]     = sel;
        req_data[i*32 +: 32]  = dat;
    endtask

    task automatic rand_in();
        req_valid = 3'($urandom);
        req_sel   = 12'($urandom);
        req_data  = {$urandom, $urandom, $urandom};
    endtask

    int acc2;
    int ret2;

    initial begin
        model_reset();
        rst = 1'b0;
        idle_in();
        #1 rst = 1'b1;

        // Reset holds everything at zero regardless of inputs.
        for (int c = 0; c < 3; c++) begin
            rand_in();
            flush = 1'($urandom);
            step();
        end
        chk("rst_pend", pend_mask, 16'h0);
        rst = 1'b0;
        idle_in();
        step();
        chk("rst_release_rdy", req_ready, 3'b111);

        // Round robin: two writes per requester, regs 1..6, grant order 0,1,2,0,1,2.
        set_req(0, 4'd1, $urandom); set_req(1, 4'd2, $urandom); set_req(2, 4'd3, $urandom);
        step();
        set_req(0, 4'd4, $urandom); set_req(1, 4'd5, $urandom); set_req(2, 4'd6, $urandom);
        step();
        idle_in();
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            chk("rr_en",  rf_wrt_en,  1'b1);
            chk("rr_gnt", gnt_id,     64'(k % 3));
            chk("rr_sel", rf_wrt_sel, 64'(k + 1));
        end
        for (int c = 0; c < 3; c++) step();

        // Single-requester latency: MEM writes reg 5.
        set_req(1, 4'd5, 32'hDEADBEEF);
        step();
        idle_in();
        chk("lat_k_pend5", pend_mask[5], 1'b1);
        chk("lat_k_en",    rf_wrt_en,    1'b0);
        step();
        chk("lat_k1_en",   rf_wrt_en,    1'b1);
        chk("lat_k1_sel",  rf_wrt_sel,   4'd5);
        chk("lat_k1_gnt",  gnt_id,       2'd1);
        chk("lat_k1_data", rf_wrt_data,  32'hDEADBEEF);
        chk("lat_k1_pend5", pend_mask[5], 1'b1);
        step();
        chk("lat_k2_pend5", pend_mask[5], 1'b0);
        chk("lat_k2_rf5",   rf_img[5],    32'hDEADBEEF);

        // Pending counter: second reg 7 enqueue lands on the first one's retire edge.
        set_req(0, 4'd7, $urandom);
        step();
        idle_in();
        chk("pc_a_q", pend_mask[7], 1'b1);
        step();
        chk("pc_a_stg", pend_mask[7], 1'b1);
        set_req(0, 4'd7, $urandom);
        step();
        idle_in();
        chk("pc_overlap", pend_mask[7], 1'b1);
        step();
        chk("pc_b_stg_en", rf_wrt_en,    1'b1);
        chk("pc_b_stg",    pend_mask[7], 1'b1);
        step();
        chk("pc_clear",    pend_mask[7], 1'b0);

        // Backpressure: ACC holds valid 5 cycles while ALU and MEM stay busy.
        acc2 = 0;
        ret2 = 0;
        for (int c = 0; c < 7; c++) begin
            set_req(0, 4'($urandom), $urandom);
            set_req(1, 4'($urandom), $urandom);
            if (c < 5) set_req(2, 4'($urandom), $urandom);
            else       req_valid[2] = 1'b0;
            if (req_valid[2] && req_ready[2]) acc2++;
            step();
            if (rf_wrt_en && gnt_id == 2'd2) ret2++;
            if (c == 1) chk("bp_rdy2_full", req_ready[2], 1'b0);
        end
        idle_in();
        for (int c = 0; c < 8; c++) begin
            step();
            if (rf_wrt_en && gnt_id == 2'd2) ret2++;
        end
        chk("bp_no_loss", 64'(ret2), 64'(acc2));

        // Flush with 4 queued and 1 staged.
        set_req(0, 4'd8, $urandom); set_req(1, 4'd9, $urandom); set_req(2, 4'd10, $urandom);
        step();
        set_req(0, 4'd11, $urandom); set_req(1, 4'd12, $urandom); set_req(2, 4'd13, $urandom);
        step();
        idle_in();
        step();
        chk("fl_pre_en", rf_wrt_en, 1'b1);
        req_valid = 3'b111;
        flush     = 1'b1;
        step();
        idle_in();
        chk("fl_en",   rf_wrt_en, 1'b0);
        chk("fl_pend", pend_mask, 16'h0);
        chk("fl_rdy",  req_ready, 3'b111);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("fl_quiet", rf_wrt_en, 1'b0);
        end
        set_req(0, 4'd3, 32'h0BADF00D);
        step();
        idle_in();
        chk("fl_post_k_en", rf_wrt_en, 1'b0);
        step();
        chk("fl_post_k1_en",  rf_wrt_en,  1'b1);
        chk("fl_post_k1_sel", rf_wrt_sel, 4'd3);
        step();
        chk("fl_post_rf3", rf_img[3], 32'h0BADF00D);

        // Random traffic with occasional flush and one mid-run reset.
        for (int c = 0; c < 600; c++) begin
            rand_in();
            if ($urandom_range(0, 3) == 0) req_valid = 3'b111;
            flush = ($urandom_range(0, 24) == 0);
            rst   = (c == 300 || c == 301);
            step();
        end
        rst = 1'b0;
        idle_in();
        for (int c = 0; c < 8; c++) step();
        chk("end_pend", pend_mask, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
